// File: rtl/ctrl_ob_fill_pkg.sv
// Shared state type, counter width and size check for the output-buffer fill controller.
`ifndef HW_LUT_PE_COLS
`define HW_LUT_PE_COLS 4
`endif
`ifndef HW_DSP_PE_COLS
`define HW_DSP_PE_COLS 2
`endif
`ifndef HW_BS_OUT_BUF_DEPTH
`define HW_BS_OUT_BUF_DEPTH 4
`endif
`ifndef HW_BP_OUT_BUF_DEPTH
`define HW_BP_OUT_BUF_DEPTH 3
`endif

package ob_fill_pkg;

    // 17 bits so a full 2^16-beat tile can be counted without wrapping
    localparam int CNT_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HANDOFF,
        ST_DRAIN
    } fill_state_t;

    function automatic logic size_legal(input logic [15:0] size, input int depth);
        logic [CNT_W-1:0] limit;
        limit = CNT_W'(1) << depth;
        return (size != 16'd0) && ({1'b0, size} <= limit);
    endfunction

endpackage

// File: rtl/ctrl_ob_fill_if.sv
// Bundle of execute, output-buffer write, writeback and error signals around ctrl_ob_fill.
interface ctrl_ob_fill_if #(
    parameter int BS_COLS          = `HW_LUT_PE_COLS,
    parameter int BP_COLS          = `HW_DSP_PE_COLS,
    parameter int BS_OUT_BUF_DEPTH = `HW_BS_OUT_BUF_DEPTH,
    parameter int BP_OUT_BUF_DEPTH = `HW_BP_OUT_BUF_DEPTH
);
    logic                                        ex_tile_start;
    logic [15:0]                                 bs_fill_times;
    logic [15:0]                                 bp_fill_times;
    logic                                        ex_ready;
    logic                                        bs_ex_valid;
    logic                                        bp_ex_valid;
    logic                                        bs_out_buf_wr_en;
    logic [BS_COLS-1:0][BS_OUT_BUF_DEPTH-1:0]    bs_out_buf_wr_addr;
    logic                                        bp_out_buf_wr_en;
    logic [BP_COLS-1:0][BP_OUT_BUF_DEPTH-1:0]    bp_out_buf_wr_addr;
    logic                                        wb_tile_start;
    logic [15:0]                                 bs_bw_out_times;
    logic [15:0]                                 bp_bw_out_times;
    logic                                        wb_tile_end;
    logic                                        ex_tile_done;
    logic                                        err_clr;
    logic                                        err_cfg;
    logic                                        err_overrun;

    modport master (
        output ex_tile_start, bs_fill_times, bp_fill_times,
        output bs_ex_valid, bp_ex_valid, wb_tile_end, err_clr,
        input  ex_ready, bs_out_buf_wr_en, bs_out_buf_wr_addr,
        input  bp_out_buf_wr_en, bp_out_buf_wr_addr, wb_tile_start,
        input  bs_bw_out_times, bp_bw_out_times, ex_tile_done,
        input  err_cfg, err_overrun
    );

    modport slave (
        input  ex_tile_start, bs_fill_times, bp_fill_times,
        input  bs_ex_valid, bp_ex_valid, wb_tile_end, err_clr,
        output ex_ready, bs_out_buf_wr_en, bs_out_buf_wr_addr,
        output bp_out_buf_wr_en, bp_out_buf_wr_addr, wb_tile_start,
        output bs_bw_out_times, bp_bw_out_times, ex_tile_done,
        output err_cfg, err_overrun
    );

endinterface

// File: rtl/ctrl_ob_fill_side_cnt.sv
// One output-buffer side: beat counter, done flag, registered write strobe/address and overrun detect.
module ob_side_cnt
    import ob_fill_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         fill_active,
    input  logic [15:0]                  size,
    input  logic                         valid,
    output logic                         wr_en,
    output logic [COLS-1:0][DEPTH-1:0]   wr_addr,
    output logic                         done,
    output logic                         done_now,
    output logic                         overrun
);

    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept   = valid && fill_active && !done;
    assign done_now = accept && (cnt == ({1'b0, size} - CNT_W'(1)));
    assign overrun  = valid && !accept;

    // Strobe and address lag the accepted beat by one cycle, lining up with the delayed write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_en <= accept;
            if (clear) begin
                cnt  <= '0;
                done <= 1'b0;
            end else if (accept) begin
                cnt     <= cnt + CNT_W'(1);
                wr_addr <= {COLS{cnt[DEPTH-1:0]}};
                if (done_now) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ctrl_ob_fill.sv
// Write-side controller for the BS/BP output buffers: fills a tile, hands it to writeback, waits for release.
module ctrl_ob_fill
    import ob_fill_pkg::*;
#(
    parameter int BS_COLS          = `HW_LUT_PE_COLS,
    parameter int BP_COLS          = `HW_DSP_PE_COLS,
    parameter int BS_OUT_BUF_DEPTH = `HW_BS_OUT_BUF_DEPTH,
    parameter int BP_OUT_BUF_DEPTH = `HW_BP_OUT_BUF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_ob_fill_if.slave bus
);

    fill_state_t state;
    logic        ex_ready_q;
    logic        wb_start_q;
    logic [15:0] bs_times_q;
    logic [15:0] bp_times_q;
    logic        err_cfg_q;
    logic        err_overrun_q;

    logic        start_seen;
    logic        sizes_ok;
    logic        tile_clear;
    logic        start_bad;
    logic        fill_active;
    logic        both_done;
    logic        bs_done, bs_done_now, bs_overrun;
    logic        bp_done, bp_done_now, bp_overrun;

    assign start_seen  = (state == ST_IDLE) && ex_ready_q && bus.ex_tile_start;
    assign sizes_ok    = size_legal(bus.bs_fill_times, BS_OUT_BUF_DEPTH)
                      && size_legal(bus.bp_fill_times, BP_OUT_BUF_DEPTH);
    assign tile_clear  = start_seen && sizes_ok;
    assign start_bad   = start_seen && !sizes_ok;
    assign fill_active = (state == ST_FILL);
    assign both_done   = (bs_done || bs_done_now) && (bp_done || bp_done_now);

    ob_side_cnt #(
        .COLS  (BS_COLS),
        .DEPTH (BS_OUT_BUF_DEPTH)
    ) u_bs_side (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (tile_clear),
        .fill_active (fill_active),
        .size        (bs_times_q),
        .valid       (bus.bs_ex_valid),
        .wr_en       (bus.bs_out_buf_wr_en),
        .wr_addr     (bus.bs_out_buf_wr_addr),
        .done        (bs_done),
        .done_now    (bs_done_now),
        .overrun     (bs_overrun)
    );

    ob_side_cnt #(
        .COLS  (BP_COLS),
        .DEPTH (BP_OUT_BUF_DEPTH)
    ) u_bp_side (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (tile_clear),
        .fill_active (fill_active),
        .size        (bp_times_q),
        .valid       (bus.bp_ex_valid),
        .wr_en       (bus.bp_out_buf_wr_en),
        .wr_addr     (bus.bp_out_buf_wr_addr),
        .done        (bp_done),
        .done_now    (bp_done_now),
        .overrun     (bp_overrun)
    );

    // ex_ready stays low for the first cycle after reset and whenever a tile owns the buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ex_ready_q <= 1'b0;
            wb_start_q <= 1'b0;
            bs_times_q <= '0;
            bp_times_q <= '0;
        end else begin
            wb_start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ex_ready_q <= 1'b1;
                    if (tile_clear) begin
                        state      <= ST_FILL;
                        ex_ready_q <= 1'b0;
                        bs_times_q <= bus.bs_fill_times;
                        bp_times_q <= bus.bp_fill_times;
                    end
                end
                ST_FILL: begin
                    if (both_done) begin
                        state      <= ST_HANDOFF;
                        wb_start_q <= 1'b1;
                    end
                end
                ST_HANDOFF: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bus.wb_tile_end) begin
                        state      <= ST_IDLE;
                        ex_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ex_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // A fresh error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cfg_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            if (start_bad) begin
                err_cfg_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_cfg_q <= 1'b0;
            end
            if (bs_overrun || bp_overrun) begin
                err_overrun_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_overrun_q <= 1'b0;
            end
        end
    end

    assign bus.ex_ready        = ex_ready_q;
    assign bus.wb_tile_start   = wb_start_q;
    assign bus.bs_bw_out_times = bs_times_q;
    assign bus.bp_bw_out_times = bp_times_q;
    assign bus.ex_tile_done    = (state == ST_DRAIN) && bus.wb_tile_end;
    assign bus.err_cfg         = err_cfg_q;
    assign bus.err_overrun     = err_overrun_q;

endmodule

// File: tb/tb_ctrl_ob_fill.sv
// Directed and randomized tile sequences for ctrl_ob_fill, checked against a beat-counting reference model.
module tb_ctrl_ob_fill;

    localparam int BS_COLS = 4;
    localparam int BP_COLS = 2;
    localparam int BS_D    = 4;
    localparam int BP_D    = 3;
    localparam int BS_SPAN = 1 << BS_D;
    localparam int BP_SPAN = 1 << BP_D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: tile phase 0 idle, 1 filling, 2 handing off, 3 draining
    int phase;
    int bs_size, bp_size, bs_beats, bp_beats, bs_lat, bp_lat;
    bit m_ready, m_err_cfg, m_err_ov;

    ctrl_ob_fill_if #(
        .BS_COLS(BS_COLS), .BP_COLS(BP_COLS),
        .BS_OUT_BUF_DEPTH(BS_D), .BP_OUT_BUF_DEPTH(BP_D)
    ) bus ();

    ctrl_ob_fill #(
        .BS_COLS(BS_COLS), .BP_COLS(BP_COLS),
        .BS_OUT_BUF_DEPTH(BS_D), .BP_OUT_BUF_DEPTH(BP_D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, advances the model, then checks the outputs a half cycle later.
    task automatic applyStimulus(input bit st, input int bsz, input int bpz,
                                 input bit bv, input bit pv, input bit te, input bit clr);
        bit bs_acc, bp_acc, exp_start, exp_done, legal;
        int bs_addr, bp_addr;
        bus.ex_tile_start = st;
        bus.bs_fill_times = 16'(bsz);
        bus.bp_fill_times = 16'(bpz);
        bus.bs_ex_valid   = bv;
        bus.bp_ex_valid   = pv;
        bus.wb_tile_end   = te;
        bus.err_clr       = clr;

        bs_acc    = bv && (phase == 1) && (bs_beats < bs_size);
        bp_acc    = pv && (phase == 1) && (bp_beats < bp_size);
        bs_addr   = bs_beats % BS_SPAN;
        bp_addr   = bp_beats % BP_SPAN;
        exp_done  = te && (phase == 3);
        exp_start = 1'b0;
        legal     = (bsz >= 1) && (bsz <= BS_SPAN) && (bpz >= 1) && (bpz <= BP_SPAN);

        if ((bv && !bs_acc) || (pv && !bp_acc)) m_err_ov = 1'b1;
        else if (clr) m_err_ov = 1'b0;
        if (st && m_ready && !legal) m_err_cfg = 1'b1;
        else if (clr) m_err_cfg = 1'b0;
        if (bs_acc) bs_beats++;
        if (bp_acc) bp_beats++;

        case (phase)
            0: if (st && m_ready && legal) begin
                phase = 1; bs_size = bsz; bp_size = bpz;
                bs_beats = 0; bp_beats = 0; bs_lat = bsz; bp_lat = bpz;
            end
            1: if (bs_beats == bs_size && bp_beats == bp_size) begin
                phase = 2; exp_start = 1'b1;
            end
            2: phase = 3;
            3: if (te) phase = 0;
            default: phase = 0;
        endcase
        m_ready = (phase == 0);

        #1;
        checkOutput("ex_tile_done", 32'(bus.ex_tile_done), 32'(exp_done));
        @(negedge clk);
        bus.ex_tile_start = 1'b0;
        bus.bs_ex_valid   = 1'b0;
        bus.bp_ex_valid   = 1'b0;
        bus.wb_tile_end   = 1'b0;
        bus.err_clr       = 1'b0;

        checkOutput("bs_wr_en", 32'(bus.bs_out_buf_wr_en), 32'(bs_acc));
        if (bs_acc)
            for (int c = 0; c < BS_COLS; c++)
                checkOutput("bs_wr_addr", 32'(bus.bs_out_buf_wr_addr[c]), 32'(bs_addr));
        checkOutput("bp_wr_en", 32'(bus.bp_out_buf_wr_en), 32'(bp_acc));
        if (bp_acc)
            for (int c = 0; c < BP_COLS; c++)
                checkOutput("bp_wr_addr", 32'(bus.bp_out_buf_wr_addr[c]), 32'(bp_addr));
        checkOutput("wb_tile_start", 32'(bus.wb_tile_start), 32'(exp_start));
        checkOutput("ex_ready", 32'(bus.ex_ready), 32'(m_ready));
        checkOutput("bs_bw_out_times", 32'(bus.bs_bw_out_times), 32'(bs_lat));
        checkOutput("bp_bw_out_times", 32'(bus.bp_bw_out_times), 32'(bp_lat));
        checkOutput("err_cfg", 32'(bus.err_cfg), 32'(m_err_cfg));
        checkOutput("err_overrun", 32'(bus.err_overrun), 32'(m_err_ov));
    endtask

    task automatic startTile(input int bsz, input int bpz);
        applyStimulus(1'b1, bsz, bpz, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic beat(input bit bv, input bit pv);
        applyStimulus(1'b0, 0, 0, bv, pv, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic endTile();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clearErrors();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Asserts reset asynchronously, checks outputs have already dropped, then releases on a falling edge.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_bs_wr_en", 32'(bus.bs_out_buf_wr_en), 32'd0);
        checkOutput("rst_bs_wr_addr", 32'(bus.bs_out_buf_wr_addr), 32'd0);
        checkOutput("rst_bp_wr_en", 32'(bus.bp_out_buf_wr_en), 32'd0);
        checkOutput("rst_bp_wr_addr", 32'(bus.bp_out_buf_wr_addr), 32'd0);
        checkOutput("rst_ex_ready", 32'(bus.ex_ready), 32'd0);
        checkOutput("rst_wb_tile_start", 32'(bus.wb_tile_start), 32'd0);
        checkOutput("rst_ex_tile_done", 32'(bus.ex_tile_done), 32'd0);
        checkOutput("rst_bs_bw_out_times", 32'(bus.bs_bw_out_times), 32'd0);
        checkOutput("rst_bp_bw_out_times", 32'(bus.bp_bw_out_times), 32'd0);
        checkOutput("rst_err_cfg", 32'(bus.err_cfg), 32'd0);
        checkOutput("rst_err_overrun", 32'(bus.err_overrun), 32'd0);
        phase = 0; m_ready = 1'b0; m_err_cfg = 1'b0; m_err_ov = 1'b0;
        bs_size = 0; bp_size = 0; bs_beats = 0; bp_beats = 0; bs_lat = 0; bp_lat = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int bsz, bpz;
        bus.ex_tile_start = 1'b0; bus.bs_fill_times = '0; bus.bp_fill_times = '0;
        bus.bs_ex_valid = 1'b0; bus.bp_ex_valid = 1'b0;
        bus.wb_tile_end = 1'b0; bus.err_clr = 1'b0;

        @(negedge clk);
        doReset();
        idle(1);

        // Basic tile 4/3 with staggered valids and a long writeback
        startTile(4, 3);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b1);
        idle(10);
        endTile();
        idle(1);

        // Both sides finish together, then a start during DRAIN is ignored
        startTile(2, 2);
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b1);
        idle(1);
        startTile(5, 5);
        endTile();
        startTile(5, 5);
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b1);
        idle(2);
        endTile();

        // Illegal sizes, including an error arriving together with err_clr
        startTile(0, 3);
        clearErrors();
        startTile(3, BP_SPAN + 1);
        applyStimulus(1'b1, BS_SPAN + 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        clearErrors();
        startTile(BS_SPAN, BP_SPAN);
        for (int i = 0; i < BS_SPAN; i++) beat(1'b1, 1'b1);
        idle(1);
        endTile();

        // Extra BS beat after its four are done, BP still filling
        startTile(4, 5);
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b1);
        idle(1);
        endTile();
        clearErrors();

        // Randomized tiles with occasional illegal sizes
        for (int t = 0; t < 20; t++) begin
            bsz = $urandom_range(1, BS_SPAN);
            bpz = $urandom_range(1, BP_SPAN);
            if ($urandom_range(0, 7) == 0) bsz = ($urandom_range(0, 1) == 0) ? 0 : BS_SPAN + 1;
            startTile(bsz, bpz);
            for (int k = 0; k < 300 && phase == 1; k++)
                beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (phase != 0) begin
                idle($urandom_range(1, 4));
                endTile();
            end
            if ($urandom_range(0, 1) == 0) clearErrors();
        end

        // Reset in the middle of a fill, then a fresh tile starts at address 0
        startTile(4, 4);
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b1);
        #2;
        doReset();
        idle(1);
        startTile(2, 1);
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        idle(1);
        endTile();
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_ob_fill.md
Name: ctrl_ob_fill

Overview:
Write-side controller for the BS (LUT-PE) and BP (DSP-PE) output buffers. It counts result beats from both PE arrays into the buffers and generates the per-column write enables and addresses. Once both buffers hold a complete tile, it hands the tile off to the writeback controller with a start pulse and the beat counts. It then blocks new tiles until writeback signals completion, so a tile is never overwritten while it is being read.

Parameters:
BS_COLS, `HW_LUT_PE_COLS, number of BS output-buffer columns
BP_COLS, `HW_DSP_PE_COLS, number of BP output-buffer columns
BS_OUT_BUF_DEPTH, `HW_BS_OUT_BUF_DEPTH, BS output-buffer address width in bits
BP_OUT_BUF_DEPTH, `HW_BP_OUT_BUF_DEPTH, BP output-buffer address width in bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_tile_start  in  1  execute stage requests a new tile; accepted only when ex_ready=1
bs_fill_times  in  16  BS beats in the tile; sampled at acceptance
bp_fill_times  in  16  BP beats in the tile; sampled at acceptance
ex_ready  out  1  1 only in IDLE
bs_ex_valid  in  1  one BS result beat this cycle
bp_ex_valid  in  1  one BP result beat this cycle
bs_out_buf_wr_en  out  1  BS buffer write strobe (all columns)
bs_out_buf_wr_addr  out  [BS_COLS-1:0][BS_OUT_BUF_DEPTH-1:0]  BS write address, same value on every column
bp_out_buf_wr_en  out  1  BP buffer write strobe
bp_out_buf_wr_addr  out  [BP_COLS-1:0][BP_OUT_BUF_DEPTH-1:0]  BP write address, same value on every column
wb_tile_start  out  1  one-cycle handoff pulse to writeback
bs_bw_out_times  out  16  latched BS beat count for writeback
bp_bw_out_times  out  16  latched BP beat count for writeback
wb_tile_end  in  1  writeback finished the tile
ex_tile_done  out  1  one-cycle pulse when the buffers are released
err_clr  in  1  clears sticky errors
err_cfg  out  1  sticky: a start was rejected for an illegal size
err_overrun  out  1  sticky: a valid beat arrived outside the expected window

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all counters, done flags, latches and outputs go to 0.
  - ex_ready=1 once out of reset.
  - Reset asserted mid-tile abandons the tile; no pulse is emitted.
- FSM states: IDLE, FILL, HANDOFF, DRAIN.
- IDLE:
  - ex_tile_start with both sizes legal → latch both sizes into bs_bw_out_times / bp_bw_out_times, clear counters and done flags, go to FILL.
  - A size is legal when it satisfies 1 ≤ size ≤ 2^DEPTH (DEPTH = the matching address-width parameter).
  - Illegal size → start is dropped, err_cfg is set, state stays IDLE.
- FILL:
  - Each bs_ex_valid with bs_done=0 writes at address bs_cnt[DEPTH-1:0], then bs_cnt increments.
  - The beat with bs_cnt == latched-1 sets bs_done.
  - BP side is identical and fully independent; both sides may be valid in the same cycle.
  - Both done (including the same cycle) → HANDOFF.
- HANDOFF: wb_tile_start=1 for exactly one cycle, then → DRAIN.
- DRAIN: wb_tile_end → ex_tile_done pulse in the same cycle (combinational), state → IDLE next cycle.
- bs_bw_out_times / bp_bw_out_times hold their values from acceptance until the next acceptance.
- Write timing:
  - wr_en and wr_addr are registered: they assert one cycle after the accepted valid beat.
  - The data path must delay write data by one stage to match.
  - wr_en is 0 whenever no write was accepted in the previous cycle.
- Overrun: bs_ex_valid or bp_ex_valid when that side is done or state≠FILL → beat is dropped, no write, err_overrun set.
- Ignored / held events:
  - ex_tile_start when ex_ready=0 is ignored with no error; upstream must hold it.
  - wb_tile_end outside DRAIN is ignored.
- Error flags: err_clr clears both; a same-cycle new error wins over err_clr.
- Counter width: counters are 17 bits so that size 2^16 never wraps; addresses use the low DEPTH bits only.

Decomposition:
- Package ob_fill_pkg holds:
  - fill FSM state enum (2-bit);
  - constant CNT_W=17;
  - helper function size_legal(size, depth).
- One sub-module, ob_side_cnt, instantiated twice (BS, BP). It contains:
  - the beat counter, done flag and registered wr_en/addr;
  - overrun detect;
  - a parameter for address width.
- The top level contains the FSM, the size latches, the handoff/done pulses and the error flags.

Test Plan:
- Basic tile: sizes bs=4, bp=3; BS valids on cycles 1-4, BP valids on cycles 2-4 → BS addr 0,1,2,3 and BP addr 0,1,2, each one cycle after its valid; one wb_tile_start pulse with bs_bw_out_times=4, bp_bw_out_times=3; wb_tile_end 10 cycles later → ex_tile_done pulse, ex_ready returns to 1.
- Simultaneous completion: sizes 2/2 with both valids on the same two cycles → a single HANDOFF, one wb_tile_start pulse.
- Busy rejection: ex_tile_start during DRAIN → ignored, ex_ready=0, latched sizes unchanged, err_cfg=0; start re-issued after ex_tile_done → accepted.
- Illegal config: bs_fill_times=0, or bp_fill_times=2^DEPTH+1 → stays IDLE, err_cfg=1; err_clr → 0.
- Overrun: a 5th BS valid after 4 completed beats → no write strobe, err_overrun=1, tile flow unaffected.
- Reset mid-FILL: rst_n low after 2 of 4 beats → all outputs 0 immediately (asynchronous); after reset a new tile starts at address 0.
